// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
// Shared constants and helpers for the round-robin stream multiplexer.
//   N_MIN/N_MAX : legal range of the channel count
//   W_MIN/W_MAX : legal range of the per-channel data width
//   rr_next()   : next channel index in round-robin order, wrapping n-1 -> 0
// -----------------------------------------------------------------------------
package stream_mux_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;
    localparam int W_MIN = 1;
    localparam int W_MAX = 64;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Priority starts at the channel after the last grant
// and wraps N-1 -> 0. The stored last grant moves only when advance is high,
// i.e. when the granted request actually transferred.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (last grant -> N-1)
//   req        : per-channel requests
//   advance    : the current grant was consumed this cycle
//   grant_oh   : one-hot grant (zero when no request)
//   grant_idx  : binary index of the granted channel
//   grant_vld  : some channel is granted
// -----------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant_oh,
    output logic [SW-1:0] grant_idx,
    output logic          grant_vld
);

    logic [SW-1:0] last_grant_q;
    logic [SW-1:0] last_grant_d;
    int unsigned   idx;

    // Walk the channels in priority order starting after last_grant; the
    // first requester wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = int'(last_grant_q);
        for (int k = 0; k < N; k++) begin
            idx = rr_next(idx, N);
            if (!grant_vld && req[idx]) begin
                grant_vld     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = SW'(idx);
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance) begin
            last_grant_d = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= SW'(N - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// N-to-1 valid/ready stream multiplexer with round-robin arbitration and a
// single output register stage (1-cycle latency, 1 beat/cycle throughput).
// Optional feature macro: STREAM_MUX_LAST_LOCK_EN -- adds in_last/out_last and
// holds the grant on one channel from its first beat until its last beat.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : per-channel valid, bit i = channel i
//   in_data    : channel i at [i*W +: W]
//   in_last    : per-channel end-of-packet (lock build only)
//   in_ready   : per-channel accept (combinational)
//   out_valid  : output register holds a beat
//   out_ready  : downstream accept
//   out_data   : registered data of the selected channel
//   out_last   : registered end-of-packet (lock build only)
//   out_sel    : index of the channel that sourced out_data
// -----------------------------------------------------------------------------
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
`ifdef STREAM_MUX_LAST_LOCK_EN
    input  logic [N-1:0]   in_last,
`endif
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
`ifdef STREAM_MUX_LAST_LOCK_EN
    output logic           out_last,
`endif
    output logic [SW-1:0]  out_sel
);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("stream_mux_rr: N out of range");
    end
    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("stream_mux_rr: W out of range");
    end

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_sel_q,   out_sel_d;

    logic          loadable;
    logic          take;
    logic [N-1:0]  req_eff;
    logic [N-1:0]  grant_oh;
    logic [SW-1:0] grant_idx;
    logic          grant_vld;
    logic [W-1:0]  mux_data;

    assign loadable = !out_valid_q || out_ready;
    assign take     = grant_vld && loadable && !rst;
    assign in_ready = (loadable && !rst) ? grant_oh : '0;

`ifdef STREAM_MUX_LAST_LOCK_EN
    logic lock_q, lock_d;
    logic out_last_q, out_last_d;
    logic mux_last;

    // While locked only the owning channel may request. The owner is always
    // the channel of the most recent transfer, which out_sel_q already holds.
    always_comb begin
        req_eff = in_valid;
        if (lock_q) begin
            req_eff = in_valid & (N'(1) << out_sel_q);
        end
    end

    assign mux_last = |(in_last & grant_oh);

    always_comb begin
        lock_d     = lock_q;
        out_last_d = out_last_q;
        if (take) begin
            lock_d     = !mux_last;
            out_last_d = mux_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q     <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`else
    assign req_eff = in_valid;
`endif

    rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_eff),
        .advance   (take),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // AND-OR select over the one-hot grant.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | (in_data[i*W +: W] & {W{grant_oh[i]}});
        end
    end

    // A loadable register either refills (drain+fill in one cycle) or empties.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_sel_d   = grant_idx;
        end else if (loadable) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
